// File: rtl/datapath_pkg.sv
// Shared decode-stage datapath definitions: register address width,
// register-B select encodings and the register address type.
package datapath_pkg;

  localparam int REG_ADDR_W = 4;

  localparam logic REGB_SEL_IN0 = 1'b0;
  localparam logic REGB_SEL_IN1 = 1'b1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : datapath_pkg

// File: rtl/mux_reg_b_mux2_w.sv
// Generic width-parameterised 2:1 mux shared across the datapath.
// An unknown select propagates as X rather than defaulting to either input.
module mux2_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule : mux2_w

// File: rtl/mux_reg_b.sv
// Register-B source-select mux: combinational rn2 for the register file plus a
// captured shadow copy for hazard logic. Optional rn2_is_zero via MUX_REG_B_ZERO_FLAG_EN.
module mux_reg_b
  import datapath_pkg::*;
#(
  parameter int                ADDR_W   = REG_ADDR_W,
  parameter logic [ADDR_W-1:0] RST_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] in0,
  input  logic [ADDR_W-1:0] in1,
  input  logic              regB,
  input  logic              en,
  output logic [ADDR_W-1:0] rn2,
  output logic [ADDR_W-1:0] rn2_q,
  output logic              regB_q,
  output logic              rn2_chg
`ifdef MUX_REG_B_ZERO_FLAG_EN
  ,output logic             rn2_is_zero
`endif
);

  logic [ADDR_W-1:0] rn2_d;
  logic              regB_d;
  logic              rn2_chg_d;
  logic              rn2_chg_q;

  mux2_w #(
    .W (ADDR_W)
  ) u_mux (
    .in0 (in0),
    .in1 (in1),
    .sel (regB),
    .y   (rn2)
  );

  // Capture next-state: the change pulse compares against the previous capture only
  always_comb begin
    rn2_d     = rn2_q;
    regB_d    = regB_q;
    rn2_chg_d = 1'b0;
    if (en) begin
      rn2_d     = rn2;
      regB_d    = regB;
      rn2_chg_d = (rn2 != rn2_q);
    end else begin
      rn2_d     = rn2_q;
      regB_d    = regB_q;
      rn2_chg_d = 1'b0;
    end
  end

  // Shadow registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rn2_q     <= RST_ADDR;
      regB_q    <= REGB_SEL_IN0;
      rn2_chg_q <= 1'b0;
    end else begin
      rn2_q     <= rn2_d;
      regB_q    <= regB_d;
      rn2_chg_q <= rn2_chg_d;
    end
  end

  assign rn2_chg = rn2_chg_q;

`ifdef MUX_REG_B_ZERO_FLAG_EN
  // Register 0 is hardwired zero, so forwarding can be skipped
  assign rn2_is_zero = (rn2 == {ADDR_W{1'b0}});
`endif

endmodule : mux_reg_b

// File: tb/tb_mux_reg_b.sv
// Self-checking bench for mux_reg_b: per-cycle comparison against a
// capture-history model plus directed literal expectations.
module tb_mux_reg_b;

  logic       clk;
  logic       rst_n;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       regB;
  logic       en;
  logic [3:0] rn2;
  logic [3:0] rn2_q;
  logic       regB_q;
  logic       rn2_chg;
`ifdef MUX_REG_B_ZERO_FLAG_EN
  logic       rn2_is_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit comp_en = 1'b0;

  // Model: last captured address, select of that capture, and whether it changed
  logic [3:0] m_last;
  logic       m_sel;
  logic       m_pulse;

  mux_reg_b dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in0     (in0),
    .in1     (in1),
    .regB    (regB),
    .en      (en),
    .rn2     (rn2),
    .rn2_q   (rn2_q),
    .regB_q  (regB_q),
    .rn2_chg (rn2_chg)
`ifdef MUX_REG_B_ZERO_FLAG_EN
    ,.rn2_is_zero (rn2_is_zero)
`endif
  );

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sel_addr(input logic s, input logic [3:0] a, input logic [3:0] b);
    return (s == 1'b1) ? b : a;
  endfunction

  // Model of the capture history; reset forgets every capture
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last  <= 4'b0000;
      m_sel   <= 1'b0;
      m_pulse <= 1'b0;
    end else if (en) begin
      m_pulse <= (sel_addr(regB, in0, in1) != m_last);
      m_last  <= sel_addr(regB, in0, in1);
      m_sel   <= regB;
    end else begin
      m_pulse <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (comp_en) begin
      chk("rn2_cyc", rn2, sel_addr(regB, in0, in1));
      chk("rn2_q_cyc", rn2_q, m_last);
      chk("regB_q_cyc", {3'b000, regB_q}, {3'b000, m_sel});
      chk("rn2_chg_cyc", {3'b000, rn2_chg}, {3'b000, m_pulse});
`ifdef MUX_REG_B_ZERO_FLAG_EN
      chk("zero_cyc", {3'b000, rn2_is_zero}, {3'b000, (sel_addr(regB, in0, in1) == 4'b0000)});
`endif
    end
  end

  task automatic drive(input logic e, input logic s, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #2;
    en   = e;
    regB = s;
    in0  = a;
    in1  = b;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    in0   = 4'b1010;
    in1   = 4'b1101;
    regB  = 1'b0;
    #1;
    chk("rn2_in0_nocl", rn2, 4'b1010);
    chk("rst_rn2_q", rn2_q, 4'b0000);
    chk("rst_regB_q", {3'b000, regB_q}, 4'b0000);
    chk("rst_chg", {3'b000, rn2_chg}, 4'b0000);
    #4;
    regB = 1'b1;
    #1;
    chk("rn2_in1_nocl", rn2, 4'b1101);

    @(negedge clk);
    rst_n   = 1'b1;
    comp_en = 1'b1;

    drive(1'b1, 1'b0, 4'b1010, 4'b1101);
    drive(1'b1, 1'b1, 4'b1010, 4'b1101);
    @(negedge clk);
    chk("cap0_rn2_q", rn2_q, 4'b1010);
    chk("cap0_regB_q", {3'b000, regB_q}, 4'b0000);
    chk("cap0_chg", {3'b000, rn2_chg}, 4'b0001);
    drive(1'b0, 1'b0, 4'b1010, 4'b1101);
    @(negedge clk);
    chk("cap1_rn2_q", rn2_q, 4'b1101);
    chk("cap1_regB_q", {3'b000, regB_q}, 4'b0001);
    chk("cap1_chg", {3'b000, rn2_chg}, 4'b0001);
    drive(1'b0, 1'b1, 4'b1010, 4'b1101);
    @(negedge clk);
    chk("hold_rn2", rn2, 4'b1101);
    chk("hold_rn2_q", rn2_q, 4'b1101);
    chk("hold_chg", {3'b000, rn2_chg}, 4'b0000);
    drive(1'b0, 1'b0, 4'b1010, 4'b1101);
    @(negedge clk);
    chk("hold2_rn2", rn2, 4'b1010);
    chk("hold2_rn2_q", rn2_q, 4'b1101);
    chk("hold2_regB_q", {3'b000, regB_q}, 4'b0001);

    // Mid-run asynchronous reset, while en is high
    drive(1'b1, 1'b1, 4'b1010, 4'b1101);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("mrst_rn2_q", rn2_q, 4'b0000);
    chk("mrst_regB_q", {3'b000, regB_q}, 4'b0000);
    chk("mrst_chg", {3'b000, rn2_chg}, 4'b0000);
    chk("mrst_rn2", rn2, 4'b1101);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal candidates: only the first capture after reset differs
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i[0], 4'b0110, 4'b0110);
      @(negedge clk);
      chk("eq_rn2", rn2, 4'b0110);
      chk("eq_chg", {3'b000, rn2_chg}, (i == 1) ? 4'b0001 : 4'b0000);
    end

`ifdef MUX_REG_B_ZERO_FLAG_EN
    drive(1'b0, 1'b0, 4'b0000, 4'b0011);
    #1;
    chk("zero_hi", {3'b000, rn2_is_zero}, 4'b0001);
    drive(1'b0, 1'b1, 4'b0000, 4'b0011);
    #1;
    chk("zero_lo", {3'b000, rn2_is_zero}, 4'b0000);
`endif

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_reg_b
